// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: sample write, TAPS-cycle MAC address sequencing, result flag.
// Optional FIR_OUT_HOLD_EN holds out_valid until out_ready.
module fir_tap_sequencer #(
  parameter int TAPS    = 8,
  parameter int ADDR_W  = 3,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);
  localparam logic [2:0] D_LAST =
    3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
  localparam bit HAS_DRAIN = (MAC_LAT > 0);

  state_t state, nstate;
  logic [ADDR_W-1:0] k, nk;
  logic [ADDR_W-1:0] wr_ptr, n_wr_ptr;
  logic [2:0] dcnt, n_dcnt;
  logic done_exit;

  logic              n_in_ready;
  logic              n_wr_en;
  logic [ADDR_W-1:0] n_wr_addr;
  logic [ADDR_W-1:0] n_rd_addr;
  logic [ADDR_W-1:0] n_coef_addr;
  logic              n_acc_clr;
  logic              n_acc_en;
  logic              n_out_valid;
  logic              n_busy;

`ifdef FIR_OUT_HOLD_EN
  assign done_exit = out_ready;
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign done_exit = 1'b1;
`endif

  always_comb begin
    nstate   = state;
    nk       = k;
    n_dcnt   = dcnt;
    n_wr_ptr = wr_ptr;
    case (state)
      IDLE: begin
        if (in_valid && in_ready)
          nstate = LOAD;
      end
      LOAD: begin
        nstate = MAC;
        nk     = '0;
      end
      MAC: begin
        if (k == K_LAST) begin
          n_wr_ptr = wr_ptr + 1'b1;
          n_dcnt   = '0;
          nstate   = HAS_DRAIN ? DRAIN : DONE;
        end else begin
          nk = k + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == D_LAST)
          nstate = DONE;
        else
          n_dcnt = dcnt + 1'b1;
      end
      DONE: begin
        if (done_exit)
          nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    n_in_ready  = (nstate == IDLE);
    n_busy      = (nstate != IDLE);
    n_wr_en     = (nstate == LOAD);
    n_acc_clr   = (nstate == LOAD);
    n_acc_en    = (nstate == MAC);
    n_out_valid = (nstate == DONE);
    n_wr_addr   = wr_addr;
    n_rd_addr   = rd_addr;
    n_coef_addr = coef_addr;
    if (nstate == LOAD)
      n_wr_addr = wr_ptr;
    if (nstate == MAC) begin
      n_coef_addr = nk;
      n_rd_addr   = wr_ptr - nk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      dcnt      <= '0;
      wr_ptr    <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      coef_addr <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nstate;
      k         <= nk;
      dcnt      <= n_dcnt;
      wr_ptr    <= n_wr_ptr;
      in_ready  <= n_in_ready;
      wr_en     <= n_wr_en;
      wr_addr   <= n_wr_addr;
      rd_addr   <= n_rd_addr;
      coef_addr <= n_coef_addr;
      acc_clr   <= n_acc_clr;
      acc_en    <= n_acc_en;
      out_valid <= n_out_valid;
      busy      <= n_busy;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer (TAPS=8, MAC_LAT=1).
// Expected write addresses queue up at acceptance and are checked at LOAD.
module tb_fir_tap_sequencer;

  localparam int TAPS    = 8;
  localparam int ADDR_W  = 3;
  localparam int MAC_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] coef_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [ADDR_W-1:0] model_wp;
  logic [ADDR_W-1:0] exp_q[$];

  fir_tap_sequencer #(
    .TAPS(TAPS),
    .ADDR_W(ADDR_W),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rd_addr(rd_addr),
    .coef_addr(coef_addr),
    .acc_clr(acc_clr),
    .acc_en(acc_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk("ready_wait", {31'b0, in_ready}, 32'd1);
  endtask

  function automatic logic [14:0] all_out();
    return {in_ready, wr_en, wr_addr, rd_addr, coef_addr,
            acc_clr, acc_en, out_valid, busy};
  endfunction

  task automatic run_sample(input bit hold, input bit gap);
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;
    wait_ready();
    in_valid = 1'b1;
    step();
    exp_q.push_back(model_wp);
    model_wp = model_wp + 1'b1;
    if (gap)
      chk("accept_gap", cyc - last_acc, TAPS + MAC_LAT + 3);
    last_acc = cyc;
    if (!hold)
      in_valid = 1'b0;
    chk("load_ctl", {wr_en, acc_clr, acc_en, in_ready, busy},
        5'b11001);
    wa = exp_q.pop_front();
    chk("wr_addr", wr_addr, wa);
    for (int i = 0; i < TAPS; i++) begin
      step();
      ra = wa - ADDR_W'(i);
      chk("mac_ctl", {acc_en, acc_clr, wr_en, in_ready, out_valid},
          5'b10000);
      chk("coef_addr", coef_addr, i);
      chk("rd_addr", rd_addr, ra);
    end
    for (int i = 0; i < MAC_LAT; i++) begin
      step();
      chk("drain_ctl", {acc_en, out_valid, busy, in_ready}, 4'b0010);
    end
    step();
    chk("done_ctl", {out_valid, busy, in_ready, acc_en}, 4'b1100);
    chk("ov_latency", cyc - last_acc, TAPS + MAC_LAT + 1);
    step();
    chk("idle_ctl", {out_valid, busy, in_ready, wr_en}, 4'b0010);
    chk("addr_hold", {wr_addr, coef_addr}, {wa, 3'd7});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_out_c1", all_out(), 15'd0);
    step();
    chk("rst_out_c2", all_out(), 15'd0);
    rst = 1'b0;
    model_wp = '0;
    exp_q.delete();
    step();
    chk("first_ready", {in_ready, busy}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bit ov_seen;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    model_wp  = '0;

    // rst wins over a simultaneous in_valid
    do_reset();
    in_valid = 1'b0;

    run_sample(1'b0, 1'b0);

    // back-to-back with wrap-around of the write pointer
    do_reset();
    for (int s = 0; s < 10; s++)
      run_sample(1'b1, s != 0);
    in_valid = 1'b0;

    // abort mid-MAC on the second sample
    do_reset();
    run_sample(1'b0, 1'b0);
    wait_ready();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++)
      step();
    chk("pre_abort_k", {acc_en, coef_addr}, {1'b1, 3'd4});
    rst = 1'b1;
    step();
    chk("abort_out", all_out(), 15'd0);
    rst = 1'b0;
    model_wp = '0;
    exp_q.delete();
    ov_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      ov_seen = ov_seen | out_valid;
    end
    chk("abort_no_ov", {31'b0, ov_seen}, 32'd0);
    run_sample(1'b0, 1'b0);

`ifdef FIR_OUT_HOLD_EN
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < TAPS + MAC_LAT + 1; i++)
      step();
    chk("hold_c1", {out_valid, in_ready, busy}, 3'b101);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_cn", {out_valid, in_ready, busy}, 3'b101);
    end
    out_ready = 1'b1;
    step();
    chk("hold_exit", {out_valid, in_ready, busy}, 3'b010);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
